// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

  // Default line setup: 250 MHz system clock driving a 10 kbit/s line.
  localparam int DEFAULT_CLOCK_FREQUENCY = 250_000_000;
  localparam int DEFAULT_BAUD_RATE       = 10_000;

  // Parity selection codes.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous first-word-fall-through FIFO that queues words for the transmitter.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             doPush;
  logic             doPop;

  // Pushes into a full FIFO and pops from an empty one are ignored.
  assign doPush = i_push && !o_full;
  assign doPop  = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping; reset discards every queued word.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PTR_ONE;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_ONE;
      end
      if (doPush && !doPop) begin
        count_q <= count_q + CNT_ONE;
      end else if (doPop && !doPush) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  // Storage array; contents need no reset because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= i_data;
    end
  end

  assign o_data  = mem_q[rdPtr_q];
  assign o_full  = (count_q == DEPTH_C);
  assign o_empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_configurable.sv
// Parametrised UART transmitter: queued words are framed with start, data, optional parity and stop bits.
module uart_tx_configurable
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
  parameter int BAUD_RATE       = DEFAULT_BAUD_RATE,
  parameter int DATA_BITS       = 8,
  parameter int PARITY_MODE     = PARITY_NONE,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy
);

  localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int BAUD_W         = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int BIT_W          = $clog2(DATA_BITS + 1);
  localparam bit HAS_PARITY     = (PARITY_MODE != PARITY_NONE);

  localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CYCLES_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic              LAST_STOP = (STOP_BITS == 2);
  localparam logic              PAR_SEED  = (PARITY_MODE == PARITY_ODD);

  if (CYCLES_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx_configurable: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_width
    $error("uart_tx_configurable: DATA_BITS must be in 5..9");
  end
  if ((PARITY_MODE < 0) || (PARITY_MODE > 2)) begin : g_bad_parity
    $error("uart_tx_configurable: PARITY_MODE must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
    $error("uart_tx_configurable: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_t       state_q, state_d;
  logic [BAUD_W-1:0]    baudCnt_q, baudCnt_d;
  logic [BIT_W-1:0]     bitCnt_q, bitCnt_d;
  logic                 stopCnt_q, stopCnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;

  logic [DATA_BITS-1:0] fifoData;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 fifoPush;
  logic                 fifoPop;
  logic                 baudDone;

  // Only the current full flag gates acceptance, so a same-cycle pop never frees a slot early.
  assign fifoPush = i_valid && !fifoFull;
  assign baudDone = (baudCnt_q == LAST_BAUD);

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_reset (i_reset),
    .i_push  (fifoPush),
    .i_data  (i_data),
    .i_pop   (fifoPop),
    .o_data  (fifoData),
    .o_full  (fifoFull),
    .o_empty (fifoEmpty)
  );

  // Frame sequencer: advances one bit per baud period and pops the next word at frame boundaries.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitCnt_d  = bitCnt_q;
    stopCnt_d = stopCnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    fifoPop   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baudDone) begin
          baudCnt_d = '0;
          state_d   = DATA;
        end else begin
          baudCnt_d = baudCnt_q + BAUD_ONE;
        end
      end
      DATA: begin
        if (baudDone) begin
          baudCnt_d = '0;
          shift_d   = shift_q >> 1;
          parity_d  = parity_q ^ shift_q[0];
          if (bitCnt_q == LAST_BIT) begin
            bitCnt_d = '0;
            if (HAS_PARITY) begin
              state_d = PARITY;
            end else begin
              state_d = STOP;
            end
          end else begin
            bitCnt_d = bitCnt_q + BIT_ONE;
          end
        end else begin
          baudCnt_d = baudCnt_q + BAUD_ONE;
        end
      end
      PARITY: begin
        if (baudDone) begin
          baudCnt_d = '0;
          state_d   = STOP;
        end else begin
          baudCnt_d = baudCnt_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (baudDone) begin
          baudCnt_d = '0;
          if (stopCnt_q == LAST_STOP) begin
            stopCnt_d = 1'b0;
            if (!fifoEmpty) begin
              fifoPop = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stopCnt_d = 1'b1;
          end
        end else begin
          baudCnt_d = baudCnt_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fifoPop) begin
      shift_d   = fifoData;
      parity_d  = PAR_SEED;
      baudCnt_d = '0;
      bitCnt_d  = '0;
      stopCnt_d = 1'b0;
    end
  end

  // Line level for the upcoming cycle, derived from next state so the output flop lines up with each bit.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  // State registers; reset abandons any frame in flight and parks the line high.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitCnt_q  <= '0;
      stopCnt_q <= 1'b0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitCnt_q  <= bitCnt_d;
      stopCnt_q <= stopCnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  assign o_ready = !fifoFull;
  assign o_tx    = tx_q;
  assign o_busy  = (state_q != IDLE) || !fifoEmpty;

endmodule

// File: tb/tb_uart_tx_configurable.sv
// Directed bench for uart_tx_configurable: four instances cover 8N1, even/odd parity and 7-bit/2-stop framing.
module tb_uart_tx_configurable;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dataA = '0, dataE = '0, dataO = '0;
  logic [6:0] data7 = '0;
  logic       validA = 1'b0, validE = 1'b0, validO = 1'b0, valid7 = 1'b0;
  logic       txA, txE, txO, tx7;
  logic       busyA, busyE, busyO, busy7;
  logic       readyA, readyE, readyO, ready7;

  int checks = 0;
  int failures = 0;

  int   accepted;
  logic readyAfter [6];

  // 8N1 instance, also used for the FIFO and reset scenarios.
  uart_tx_configurable #(.CLOCK_FREQUENCY(40), .BAUD_RATE(10), .DATA_BITS(8),
                         .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dutA (
    .clk(clk), .i_reset(reset), .i_data(dataA), .i_valid(validA),
    .o_ready(readyA), .o_tx(txA), .o_busy(busyA));

  uart_tx_configurable #(.CLOCK_FREQUENCY(40), .BAUD_RATE(10), .DATA_BITS(8),
                         .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dutE (
    .clk(clk), .i_reset(reset), .i_data(dataE), .i_valid(validE),
    .o_ready(readyE), .o_tx(txE), .o_busy(busyE));

  uart_tx_configurable #(.CLOCK_FREQUENCY(40), .BAUD_RATE(10), .DATA_BITS(8),
                         .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dutO (
    .clk(clk), .i_reset(reset), .i_data(dataO), .i_valid(validO),
    .o_ready(readyO), .o_tx(txO), .o_busy(busyO));

  uart_tx_configurable #(.CLOCK_FREQUENCY(40), .BAUD_RATE(10), .DATA_BITS(7),
                         .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut7 (
    .clk(clk), .i_reset(reset), .i_data(data7), .i_valid(valid7),
    .o_ready(ready7), .o_tx(tx7), .o_busy(busy7));

  // Free-running system clock.
  always #5 clk = ~clk;

  // Hard stop in case a scenario stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic txOf(input int sel);
    case (sel)
      0:       return txA;
      1:       return txE;
      2:       return txO;
      default: return tx7;
    endcase
  endfunction

  function automatic logic busyOf(input int sel);
    case (sel)
      0:       return busyA;
      1:       return busyE;
      2:       return busyO;
      default: return busy7;
    endcase
  endfunction

  task automatic setIn(input int sel, input logic v, input logic [7:0] d);
    case (sel)
      0:       begin validA = v; dataA = d; end
      1:       begin validE = v; dataE = d; end
      2:       begin validO = v; dataO = d; end
      default: begin valid7 = v; data7 = d[6:0]; end
    endcase
  endtask

  // Samples nBits bit periods; each bit becomes '0'/'1', or 'x' if the line moved inside the period.
  task automatic captureBits(input int sel, input int nBits, input bit primed, output string s);
    logic v, first;
    bit   same;
    s = "";
    for (int b = 0; b < nBits; b++) begin
      same  = 1'b1;
      first = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        if (!(primed && b == 0 && c == 0)) @(negedge clk);
        v = txOf(sel);
        if (c == 0) first = v;
        else if (v !== first) same = 1'b0;
      end
      if (!same) s = {s, "x"};
      else if (first === 1'b1) s = {s, "1"};
      else if (first === 1'b0) s = {s, "0"};
      else s = {s, "x"};
    end
  endtask

  // Polls for the falling start edge, bounded by a cycle budget.
  task automatic waitStart(input int sel, input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (txOf(sel) === 1'b0) found = 1'b1;
    end
  endtask

  // Holds valid on instance A and steps through the word list on each accepting edge.
  task automatic produce(input logic [7:0] words [6], input int n);
    logic r;
    int   guard;
    accepted = 0;
    guard    = 0;
    for (int i = 0; i < 6; i++) readyAfter[i] = 1'bx;
    setIn(0, 1'b1, words[0]);
    while (accepted < n && guard < 300) begin
      r = readyA;
      @(negedge clk);
      guard++;
      if (r) begin
        readyAfter[accepted] = readyA;
        accepted++;
        if (accepted < n) setIn(0, 1'b1, words[accepted]);
        else setIn(0, 1'b0, 8'h00);
      end
    end
    setIn(0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (txA !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx: got %b expected 1", txA); end
    checks++; if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busyA); end
    checks++; if (readyA !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", readyA); end
    checks++; if ({txE, txO, tx7} !== 3'b111) begin failures++; $display("[TB] FAIL reset_tx_others: got %b expected 111", {txE, txO, tx7}); end
  endtask

  // One word into an idle instance: checks start latency, bit pattern, frame length and busy release.
  task automatic test_single_frame(input int sel, input logic [7:0] word, input string name, input string expected);
    string obs;
    setIn(sel, 1'b1, word);
    @(negedge clk);
    setIn(sel, 1'b0, 8'h00);
    checks++; if (txOf(sel) !== 1'b1) begin failures++; $display("[TB] FAIL %s_latency: tx got %b expected 1", name, txOf(sel)); end
    checks++; if (busyOf(sel) !== 1'b1) begin failures++; $display("[TB] FAIL %s_busy_queued: got %b expected 1", name, busyOf(sel)); end
    captureBits(sel, expected.len(), 1'b0, obs);
    checks++; if (obs != expected) begin failures++; $display("[TB] FAIL %s_frame: got %s expected %s", name, obs, expected); end
    checks++; if (busyOf(sel) !== 1'b1) begin failures++; $display("[TB] FAIL %s_busy_last_stop: got %b expected 1", name, busyOf(sel)); end
    @(negedge clk);
    checks++; if (busyOf(sel) !== 1'b0) begin failures++; $display("[TB] FAIL %s_busy_after: got %b expected 0", name, busyOf(sel)); end
    checks++; if (txOf(sel) !== 1'b1) begin failures++; $display("[TB] FAIL %s_idle_after: got %b expected 1", name, txOf(sel)); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [6];
    string      obs;
    bit         found;
    words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    obs   = "";
    fork
      produce(words, 6);
      begin
        waitStart(0, 50, found);
        if (found) captureBits(0, 61, 1'b1, obs);
      end
    join
    checks++; if (readyAfter[3] !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_after_4: got %b expected 1", readyAfter[3]); end
    checks++; if (readyAfter[4] !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready_after_5: got %b expected 0", readyAfter[4]); end
    checks++; if (accepted !== 6) begin failures++; $display("[TB] FAIL b2b_accepted: got %0d expected 6", accepted); end
    checks++;
    if (obs != {"0100000001", "0010000001", "0110000001", "0001000001", "0101000001", "0011000001", "1"}) begin
      failures++;
      $display("[TB] FAIL b2b_stream: got %s expected %s", obs,
               {"0100000001", "0010000001", "0110000001", "0001000001", "0101000001", "0011000001", "1"});
    end
    checks++; if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL b2b_busy_after: got %b expected 0", busyA); end
  endtask

  task automatic test_drop_when_full();
    logic [7:0] words [6];
    string      obs;
    bit         found;
    int         readyWhileOffered;
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00};
    obs   = "";
    readyWhileOffered = 0;
    fork
      begin
        produce(words, 5);
        setIn(0, 1'b1, 8'hFF);
        repeat (5) begin
          if (readyA !== 1'b0) readyWhileOffered++;
          @(negedge clk);
        end
        setIn(0, 1'b0, 8'h00);
      end
      begin
        waitStart(0, 50, found);
        if (found) captureBits(0, 51, 1'b1, obs);
      end
    join
    checks++; if (readyAfter[4] !== 1'b0) begin failures++; $display("[TB] FAIL drop_ready_full: got %b expected 0", readyAfter[4]); end
    checks++; if (readyWhileOffered !== 0) begin failures++; $display("[TB] FAIL drop_ready_during_ff: got %0d ready cycles expected 0", readyWhileOffered); end
    checks++;
    if (obs != {"0100010001", "0010001001", "0110011001", "0001000101", "0101010101", "1"}) begin
      failures++;
      $display("[TB] FAIL drop_stream: got %s expected %s", obs,
               {"0100010001", "0010001001", "0110011001", "0001000101", "0101010101", "1"});
    end
    checks++; if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL drop_busy_after: got %b expected 0", busyA); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] words [6];
    bit         found;
    int         lowCycles, busyCycles;
    words = '{8'h3C, 8'h5A, 8'h69, 8'h00, 8'h00, 8'h00};
    found = 1'b0;
    fork
      produce(words, 3);
      begin
        waitStart(0, 50, found);
        if (found) repeat (17) @(negedge clk);
      end
    join
    checks++; if (!found) begin failures++; $display("[TB] FAIL rst_mid_start: got no start expected start within 50 cycles"); end
    checks++; if ({txA, busyA} !== 2'b11) begin failures++; $display("[TB] FAIL rst_mid_in_bit3: got tx,busy=%b expected 11", {txA, busyA}); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (txA !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_tx: got %b expected 1", txA); end
    checks++; if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busyA); end
    checks++; if (readyA !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_ready: got %b expected 1", readyA); end
    reset = 1'b0;
    lowCycles  = 0;
    busyCycles = 0;
    repeat (120) begin
      @(negedge clk);
      if (txA !== 1'b1) lowCycles++;
      if (busyA !== 1'b0) busyCycles++;
    end
    checks++; if (lowCycles !== 0) begin failures++; $display("[TB] FAIL rst_mid_no_tx: got %0d low cycles expected 0", lowCycles); end
    checks++; if (busyCycles !== 0) begin failures++; $display("[TB] FAIL rst_mid_no_busy: got %0d busy cycles expected 0", busyCycles); end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_single_frame(0, 8'hA5, "8n1_a5", "0101001011");
    test_single_frame(1, 8'h07, "even_07", "01110000011");
    test_single_frame(2, 8'h07, "odd_07", "01110000001");
    test_single_frame(3, 8'h55, "7n2_55", "0101010111");
    test_back_to_back();
    test_drop_when_full();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_configurable.md
# uart_tx_configurable

Parametrised UART transmitter that serialises words from an internal FIFO onto a single line. Data width, parity and stop-bit count are compile-time configurable. Words enter through a ready/valid handshake, so upstream logic can queue several words without tracking line timing. It sits between a byte/word producer and the board TX pin, and supersedes the fixed 8N1 pulse-started transmitter.

## Interface
- CLOCK_FREQUENCY, 250000000, system clock in Hz
- BAUD_RATE, 10000, line rate in bit/s
- CYCLES_PER_BIT, CLOCK_FREQUENCY / BAUD_RATE, derived constant; must be ≥ 2 (elaboration error otherwise)
- DATA_BITS, 8, payload width; legal 5..9
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 4, entries; power of two, ≥ 2

Ports:
- clk  input  1  system clock; all logic on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_data  input  DATA_BITS  word to transmit; sampled only on an accepting edge
- i_valid  input  1  producer offers i_data
- o_ready  output  1  FIFO not full; equals !full
- o_tx  output  1  serial line, registered, idle high
- o_busy  output  1  high when a frame is in progress or the FIFO is non-empty

## Operation
- Reset (i_reset high at an edge): FIFO flushed, state IDLE, counters 0, o_tx = 1, o_ready = 1, o_busy = 0 from the following cycle. Reset mid-frame abandons the frame immediately. Queued words are discarded.
- Accept: a word is accepted when i_valid && o_ready are both high at an edge. i_valid while o_ready is low is ignored; the word is dropped and nothing is stored. o_ready is computed from the current full flag only; a simultaneous pop does not free a slot in that cycle.
- State machine: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: o_tx = 1. When the FIFO is non-empty, pop the head into the shift register, clear counters, enter START.
  - START: o_tx = 0 for CYCLES_PER_BIT cycles.
  - DATA: LSB first, one bit per CYCLES_PER_BIT cycles. Bit index runs 0..DATA_BITS-1.
  - PARITY: present only if PARITY_MODE ≠ 0. Even parity bit = XOR of the data bits; odd parity bit = its inverse.
  - STOP: o_tx = 1 for STOP_BITS*CYCLES_PER_BIT cycles.
  - At the last STOP cycle: if the FIFO is non-empty, pop and go straight to START (zero idle gap). Otherwise go to IDLE.
- Baud counter: 0..CYCLES_PER_BIT-1. Restarts at 0 on each frame start; it is not free-running. Counter width is $clog2(CYCLES_PER_BIT).
- Bit counter: width $clog2(DATA_BITS+1). It never exceeds DATA_BITS-1 in DATA.

## Timing
- Accepting edge N into an empty FIFO with the block IDLE: pop occurs at edge N+1, and o_tx is low from the cycle after N+1.
- Every bit, including start, parity and each stop bit, lasts exactly CYCLES_PER_BIT cycles.
- Frame length = (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) * CYCLES_PER_BIT cycles.
- o_tx is driven from a flop; no combinational path from any input to o_tx.
- o_ready falls the cycle after the accept that fills the FIFO. It rises the cycle after the pop that frees a slot.

## Structure
- Package uart_pkg holds:
  - enum uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - parity constants PARITY_NONE/ODD/EVEN
  - shared default CLOCK_FREQUENCY and BAUD_RATE
- Sub-module uart_tx_fifo: synchronous FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, i_reset, i_push, i_data, i_pop, o_data, o_full, o_empty.
  - o_data shows the head (first-word fall-through).
- Top module holds the FSM, baud and bit counters, shift register, and parity accumulator.

## Test plan
Bench uses CLOCK_FREQUENCY=40, BAUD_RATE=10 (CYCLES_PER_BIT=4).
- 8N1, push 0xA5 → o_tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. 40-cycle frame. o_busy falls after the last stop cycle.
- PARITY_MODE=2, push 0x07 → parity bit 1. PARITY_MODE=1, push 0x07 → parity bit 0. Frame is 44 cycles.
- DATA_BITS=7, STOP_BITS=2, push 0x55 → 7 data bits 1,0,1,0,1,0,1, then 8 high cycles. 40-cycle frame.
- FIFO_DEPTH=4, i_valid held high with 0x01..0x06 → o_ready deasserts after the FIFO fills. Words 0x01..0x05 are transmitted back-to-back with no idle cycles. 0x06 is accepted only once o_ready returns, and all words arrive in order.
- Reset asserted during DATA bit 3 of 0x3C with 2 words queued → o_tx = 1, o_busy = 0, o_ready = 1 the next cycle. Queued words are never transmitted.
- i_valid with 0xFF while o_ready = 0 → word not stored. The transmitted sequence contains no 0xFF.
